// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives imem, fills the IF/ID register.
// Handles decode stalls, execute redirects, HALT and illegal-target faults.
module fetch_unit #(
  parameter int              PC_W      = 10,
  parameter int              INSTR_W   = 16,
  parameter int              MEM_DEPTH = 1000,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [3:0]      HALT_OP   = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  input  logic               resume_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [PC_W-1:0]    pc_o,
  output logic               imem_en_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [PC_W-1:0]    ifid_pc_o,
  output logic               ifid_valid_o,
  output logic               halted_o,
  output logic               fault_o
);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [PC_W:0]   LP_DEPTH = (PC_W+1)'(MEM_DEPTH);
  localparam logic [PC_W-1:0] LP_LAST  = PC_W'(MEM_DEPTH - 1);

  state_t               r_state, w_state_n;
  logic [PC_W-1:0]      r_pc, w_pc_n;
  logic [INSTR_W-1:0]   r_instr, w_instr_n;
  logic [PC_W-1:0]      r_ifpc, w_ifpc_n;
  logic                 r_valid, w_valid_n;
  logic [PC_W-1:0]      w_pc_inc;
  logic                 w_bad_tgt;
  logic                 w_is_halt;

  assign w_pc_inc  = (r_pc == LP_LAST) ? '0 : r_pc + 1'b1;
  assign w_bad_tgt = {1'b0, redirect_pc_i} >= LP_DEPTH;
  assign w_is_halt = instr_i[INSTR_W-1 -: 4] == HALT_OP;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_ifpc  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_instr <= w_instr_n;
      r_ifpc  <= w_ifpc_n;
      r_valid <= w_valid_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_instr_n = r_instr;
    w_ifpc_n  = r_ifpc;
    w_valid_n = r_valid;
    if (redirect_i && r_state != S_FAULT) begin
      // Flush the wrong-path instruction; bad targets freeze the PC.
      w_valid_n = 1'b0;
      if (w_bad_tgt) begin
        w_state_n = S_FAULT;
      end else begin
        w_pc_n    = redirect_pc_i;
        w_state_n = S_RUN;
      end
    end else begin
      unique case (1'b1)
        r_state == S_RUN: begin
          if (!stall_i) begin
            w_instr_n = instr_i;
            w_ifpc_n  = r_pc;
            w_valid_n = 1'b1;
            if (w_is_halt) w_state_n = S_HALT;
            else           w_pc_n    = w_pc_inc;
          end
        end
        r_state == S_HALT: begin
          if (!stall_i) w_valid_n = 1'b0;
          if (resume_i) begin
            w_pc_n    = w_pc_inc;
            w_state_n = S_RUN;
          end
        end
        default: begin
          w_valid_n = 1'b0;
        end
      endcase
    end
  end

  assign pc_o         = r_pc;
  assign imem_en_o    = (r_state == S_RUN) & ~stall_i;
  assign ifid_instr_o = r_instr;
  assign ifid_pc_o    = r_ifpc;
  assign ifid_valid_o = r_valid;
  assign halted_o     = r_state == S_HALT;
  assign fault_o      = r_state == S_FAULT;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded directed bench for fetch_unit: stimulus pushes hand-computed
// post-edge expectations, a monitor pops and compares after each rising edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [9:0]  redirect_pc_i = '0;
  logic        resume_i = 1'b0;
  logic [15:0] instr_i;
  logic [9:0]  pc_o;
  logic        imem_en_o;
  logic [15:0] ifid_instr_o;
  logic [9:0]  ifid_pc_o;
  logic        ifid_valid_o;
  logic        halted_o;
  logic        fault_o;

  logic [15:0] mem [0:1023];

  typedef struct {
    string tag;
    int    pc;
    int    ifpc;
    bit    v;
    bit    h;
    bit    f;
    bit    en;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .resume_i     (resume_i),
    .instr_i      (instr_i),
    .pc_o         (pc_o),
    .imem_en_o    (imem_en_o),
    .ifid_instr_o (ifid_instr_o),
    .ifid_pc_o    (ifid_pc_o),
    .ifid_valid_o (ifid_valid_o),
    .halted_o     (halted_o),
    .fault_o      (fault_o)
  );

  always #5 clk = ~clk;

  assign instr_i = mem[pc_o];

  task automatic chk(input string tag, input string fld,
                     input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s.%s actual=%0h required=%0h", tag, fld, act, req);
    end
  endtask

  // Monitor: the DUT presents fresh state after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.tag, "pc", int'(pc_o), e.pc);
        if (e.ifpc >= 0) chk(e.tag, "ifid_pc", int'(ifid_pc_o), e.ifpc);
        chk(e.tag, "valid", int'(ifid_valid_o), int'(e.v));
        chk(e.tag, "halted", int'(halted_o), int'(e.h));
        chk(e.tag, "fault", int'(fault_o), int'(e.f));
        chk(e.tag, "imem_en", int'(imem_en_o), int'(e.en));
      end
    end
  end

  // One clock: apply inputs, queue the state expected after the edge.
  task automatic cyc(input string tag, input bit r, input bit s,
                     input bit rd, input int rpc, input bit rs,
                     input int epc, input int eifpc, input bit ev,
                     input bit eh, input bit ef);
    exp_t e;
    rst           = r;
    stall_i       = s;
    redirect_i    = rd;
    redirect_pc_i = rpc[9:0];
    resume_i      = rs;
    e.tag  = tag;
    e.pc   = epc;
    e.ifpc = eifpc;
    e.v    = ev;
    e.h    = eh;
    e.f    = ef;
    e.en   = !eh && !ef && !s;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[9] = 16'hF000;
    @(negedge clk);
    //        tag      rst st rd rpc    rs pc     ifpc  v  h  f
    cyc("reset",       1, 0, 0, 0,     0, 0,     0,    0, 0, 0);
    cyc("run1",        0, 0, 0, 0,     0, 1,     0,    1, 0, 0);
    cyc("run2",        0, 0, 0, 0,     0, 2,     1,    1, 0, 0);
    cyc("run3",        0, 0, 0, 0,     0, 3,     2,    1, 0, 0);
    cyc("run4",        0, 0, 0, 0,     0, 4,     3,    1, 0, 0);
    cyc("run5",        0, 0, 0, 0,     0, 5,     4,    1, 0, 0);
    cyc("stall1",      0, 1, 0, 0,     0, 5,     4,    1, 0, 0);
    cyc("stall2",      0, 1, 0, 0,     0, 5,     4,    1, 0, 0);
    cyc("stall3",      0, 1, 0, 0,     0, 5,     4,    1, 0, 0);
    cyc("release",     0, 0, 0, 0,     0, 6,     5,    1, 0, 0);
    cyc("run7",        0, 0, 0, 0,     0, 7,     6,    1, 0, 0);
    cyc("redir_stall", 0, 1, 1, 'h120, 0, 'h120, 6,    0, 0, 0);
    cyc("redir_tgt",   0, 0, 0, 0,     0, 'h121, 'h120, 1, 0, 0);
    cyc("redir8",      0, 0, 1, 8,     0, 8,     'h120, 0, 0, 0);
    cyc("run9",        0, 0, 0, 0,     0, 9,     8,    1, 0, 0);
    cyc("halt_cap",    0, 0, 0, 0,     0, 9,     9,    1, 1, 0);
    cyc("halt_flush",  0, 0, 0, 0,     0, 9,     9,    0, 1, 0);
    cyc("halt_stall",  0, 1, 0, 0,     0, 9,     9,    0, 1, 0);
    cyc("resume",      0, 0, 0, 0,     1, 10,    9,    0, 0, 0);
    cyc("run_after",   0, 0, 0, 0,     0, 11,    10,   1, 0, 0);
    cyc("resume_run",  0, 0, 0, 0,     1, 12,    11,   1, 0, 0);
    cyc("redir999",    0, 0, 1, 999,   0, 999,   11,   0, 0, 0);
    cyc("wrap",        0, 0, 0, 0,     0, 0,     999,  1, 0, 0);
    cyc("post_wrap",   0, 0, 0, 0,     0, 1,     0,    1, 0, 0);
    cyc("redir1000",   0, 0, 1, 1000,  0, 1,     0,    0, 0, 1);
    cyc("fault_hold",  0, 0, 0, 0,     0, 1,     0,    0, 0, 1);
    cyc("fault_redir", 0, 0, 1, 5,     1, 1,     0,    0, 0, 1);
    cyc("rst_fault",   1, 0, 0, 0,     0, 0,     0,    0, 0, 0);
    cyc("redir9",      0, 0, 1, 9,     0, 9,     0,    0, 0, 0);
    cyc("halt_cap2",   0, 0, 0, 0,     0, 9,     9,    1, 1, 0);
    cyc("halt_redir",  0, 0, 1, 'h20,  0, 'h20,  9,    0, 0, 0);
    cyc("redir9b",     0, 0, 1, 9,     0, 9,     9,    0, 0, 0);
    cyc("halt_cap3",   0, 0, 0, 0,     0, 9,     9,    1, 1, 0);
    cyc("rst_halt",    1, 0, 0, 0,     0, 0,     0,    0, 0, 0);
    cyc("run_rst",     0, 0, 0, 0,     0, 1,     0,    1, 0, 0);
    cyc("redir1023",   0, 1, 1, 1023,  0, 1,     0,    0, 0, 1);
    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
